exec_muldiv_stage: RTL and testbench

- Parametrised successor execute stage for RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle integer execute stage and receives already-bypassed operands from decode/bypass.
- Computes iteratively over multiple cycles, so it drives a busy/handshake protocol toward the controller instead of a fixed 1-cycle result.
- Its writeback bundle (rd addr, wen, wdata) feeds the memory-access stage register exactly like the ALU path.

---
 rtl/exec_muldiv_stage_if.sv | 32 +++
 rtl/exec_muldiv_stage.sv | 174 +++++++++++++++++
 tb/tb_exec_muldiv_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_muldiv_stage_if.sv
// Handshake and writeback bundle between the controller/decode side and the
// iterative multiply/divide execute stage.
interface exec_muldiv_stage_if #(
  parameter int XLEN      = 32,
  parameter int RD_ADDR_W = 5
);
  logic                 flush;
  logic                 stall;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [XLEN-1:0]      in_rs1;
  logic [XLEN-1:0]      in_rs2;
  logic [RD_ADDR_W-1:0] in_rd_addr;
  logic                 busy;
  logic                 out_valid;
  logic                 out_wen;
  logic [RD_ADDR_W-1:0] out_rd_addr;
  logic [XLEN-1:0]      out_wdata;

  // Controller / decode side
  modport master (
    output flush, stall, in_valid, in_op, in_rs1, in_rs2, in_rd_addr,
    input  in_ready, busy, out_valid, out_wen, out_rd_addr, out_wdata
  );

  // Execute-stage side
  modport slave (
    input  flush, stall, in_valid, in_op, in_rs1, in_rs2, in_rd_addr,
    output in_ready, busy, out_valid, out_wen, out_rd_addr, out_wdata
  );
endinterface

// File: rtl/exec_muldiv_stage.sv
// Iterative RV M-extension execute stage: shift-add multiply and restoring
// divide over XLEN cycles, with optional single-cycle multiply and a one-cycle
// early-out for divide-by-zero and signed overflow.
module exec_muldiv_stage #(
  parameter int XLEN          = 32,
  parameter int RD_ADDR_W     = 5,
  parameter bit MUL_ITERATIVE = 1'b1,
  parameter bit EARLY_OUT     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  exec_muldiv_stage_if.slave bus
);

  localparam int              CNT_W   = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic [RD_ADDR_W-1:0] rd_q;
  logic                 neg_a_q;
  logic                 neg_b_q;
  logic [XLEN-1:0]      b_q;       // multiplicand / divisor magnitude
  logic [2*XLEN-1:0]    acc_q;     // mul: {partial, multiplier}; div: low half = dividend/quotient
  logic [XLEN-1:0]      rem_q;     // partial remainder
  logic [XLEN-1:0]      result_q;

  // Sign handling applied once at the end: negate the product/quotient when the
  // operand signs differ, the remainder follows the dividend. A zero divisor
  // forces an all-ones quotient regardless of sign.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [2:0]        op,
    input logic              neg_a,
    input logic              neg_b,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem,
    input logic              b_zero
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    p = (neg_a ^ neg_b) ? -prod : prod;
    case (op)
      3'd0:                r = p[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    r = p[2*XLEN-1:XLEN];
      3'd4, 3'd5:          r = b_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
      default:             r = neg_a ? -rem : rem;
    endcase
    return r;
  endfunction

  // Input decode: signedness, magnitudes and the one-cycle completion cases.
  logic              sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              is_div_in, div_zero_in, div_ovf_in, fast_in;
  logic [2*XLEN-1:0] prod_in;
  logic [XLEN-1:0]   imm_result;
  logic              accept;

  assign bus.in_ready = (state_q == ST_IDLE) && !bus.stall;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  // Operand preparation for acceptance and the single-cycle result paths.
  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    sgn_a_in = 1'b0;
    sgn_b_in = 1'b0;
    case (bus.in_op)
      3'd1, 3'd4, 3'd6: begin sgn_a_in = 1'b1; sgn_b_in = 1'b1; end
      3'd2:             sgn_a_in = 1'b1;
      default:          ;
    endcase
    neg_a_in    = sgn_a_in && bus.in_rs1[XLEN-1];
    neg_b_in    = sgn_b_in && bus.in_rs2[XLEN-1];
    mag_a_in    = neg_a_in ? -bus.in_rs1 : bus.in_rs1;
    mag_b_in    = neg_b_in ? -bus.in_rs2 : bus.in_rs2;
    is_div_in   = bus.in_op[2];
    div_zero_in = (bus.in_rs2 == '0);
    div_ovf_in  = is_div_in && sgn_a_in && (bus.in_rs1 == MIN_VAL) && (bus.in_rs2 == '1);
    fast_in     = is_div_in ? (EARLY_OUT && (div_zero_in || div_ovf_in)) : !MUL_ITERATIVE;
    prod_in     = MUL_ITERATIVE ? '0 : ((2*XLEN)'(mag_a_in) * (2*XLEN)'(mag_b_in));
    imm_result  = fix_result(bus.in_op, neg_a_in, neg_b_in, prod_in, MIN_VAL,
                             div_zero_in ? mag_a_in : '0, div_zero_in);
  end

  // One iteration step of shift-add multiply and restoring divide.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_d;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [XLEN-1:0]   div_rem_d, div_quo_d;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh    = {rem_q, acc_q[XLEN-1]};
    rem_diff  = rem_sh - {1'b0, b_q};
    if (!rem_diff[XLEN]) begin
      div_rem_d = rem_diff[XLEN-1:0];
      div_quo_d = {acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_rem_d = rem_sh[XLEN-1:0];
      div_quo_d = {acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Control FSM and datapath registers; flush overrides everything but reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= bus.in_op;
            rd_q    <= bus.in_rd_addr;
            neg_a_q <= neg_a_in;
            neg_b_q <= neg_b_in;
            b_q     <= mag_b_in;
            acc_q   <= {{XLEN{1'b0}}, mag_a_in};
            rem_q   <= '0;
            if (fast_in) begin
              result_q <= imm_result;
              state_q  <= ST_DONE;
            end else begin
              cnt_q   <= CNT_W'(XLEN - 1);
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (op_q[2]) begin
            acc_q <= {acc_q[2*XLEN-1:XLEN], div_quo_d};
            rem_q <= div_rem_d;
          end else begin
            acc_q <= mul_acc_d;
          end
          if (cnt_q == '0) begin
            result_q <= fix_result(op_q, neg_a_q, neg_b_q, mul_acc_d, div_quo_d,
                                   div_rem_d, b_q == '0);
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (!bus.stall) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.out_wen     = bus.out_valid && (rd_q != '0);
  assign bus.out_rd_addr = rd_q;
  assign bus.out_wdata   = result_q;

endmodule

// File: tb/tb_exec_muldiv_stage.sv
// Directed bench for exec_muldiv_stage: one instance with early-out enabled,
// one with early-out disabled, both with the iterative multiplier.
module tb_exec_muldiv_stage;
  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3,
                         OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  exec_muldiv_stage_if #(.XLEN(XLEN), .RD_ADDR_W(RD_W)) bus0 ();
  exec_muldiv_stage_if #(.XLEN(XLEN), .RD_ADDR_W(RD_W)) bus1 ();

  exec_muldiv_stage #(.XLEN(XLEN), .RD_ADDR_W(RD_W), .MUL_ITERATIVE(1'b1), .EARLY_OUT(1'b1))
    dut_eo (.clk(clk), .rst(rst), .bus(bus0));
  exec_muldiv_stage #(.XLEN(XLEN), .RD_ADDR_W(RD_W), .MUL_ITERATIVE(1'b1), .EARLY_OUT(1'b0))
    dut_it (.clk(clk), .rst(rst), .bus(bus1));

  // Outputs of the instance currently under test
  logic            s_valid, s_busy, s_ready, s_wen;
  logic [RD_W-1:0] s_rd;
  logic [XLEN-1:0] s_wdata;
  assign s_valid = sel ? bus1.out_valid   : bus0.out_valid;
  assign s_busy  = sel ? bus1.busy        : bus0.busy;
  assign s_ready = sel ? bus1.in_ready    : bus0.in_ready;
  assign s_wen   = sel ? bus1.out_wen     : bus0.out_wen;
  assign s_rd    = sel ? bus1.out_rd_addr : bus0.out_rd_addr;
  assign s_wdata = sel ? bus1.out_wdata   : bus0.out_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit s, input logic v, input logic [2:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [RD_W-1:0] rd);
    if (s) begin
      bus1.in_valid = v; bus1.in_op = op; bus1.in_rs1 = a; bus1.in_rs2 = b; bus1.in_rd_addr = rd;
    end else begin
      bus0.in_valid = v; bus0.in_op = op; bus0.in_rs1 = a; bus0.in_rs2 = b; bus0.in_rd_addr = rd;
    end
  endtask

  // Present one op at the current negedge, count cycles to out_valid, check
  // result/latency/busy, then confirm the unit returns to IDLE.
  task automatic do_op(input bit s, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [RD_W-1:0] rd,
                       input logic [XLEN-1:0] exp, input int exp_lat, input string tag);
    int n;
    bit done;
    bit busy_ok;
    sel = s;
    set_in(s, 1'b1, op, a, b, rd);
    #1;
    check({tag, "_ready"}, 64'(s_ready), 64'd1);
    n = 0; done = 1'b0; busy_ok = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) set_in(s, 1'b0, 3'd0, '0, '0, '0);
      if (!s_busy) busy_ok = 1'b0;
      if (s_valid) done = 1'b1;
    end
    check({tag, "_lat"},   64'(n),       64'(exp_lat));
    check({tag, "_busy"},  64'(busy_ok), 64'd1);
    check({tag, "_wdata"}, 64'(s_wdata), 64'(exp));
    check({tag, "_rd"},    64'(s_rd),    64'(rd));
    check({tag, "_wen"},   64'(s_wen),   64'(rd != '0));
    @(negedge clk);
    check({tag, "_idle"},  64'({s_valid, s_ready}), 64'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit flag;
    bus0.flush = 1'b0; bus0.stall = 1'b0;
    bus1.flush = 1'b0; bus1.stall = 1'b0;
    set_in(1'b0, 1'b0, 3'd0, '0, '0, '0);
    set_in(1'b1, 1'b0, 3'd0, '0, '0, '0);

    // Reset state
    #12;
    check("rst_valid", 64'(bus0.out_valid),   64'd0);
    check("rst_busy",  64'(bus0.busy),        64'd0);
    check("rst_wdata", 64'(bus0.out_wdata),   64'd0);
    check("rst_rd",    64'(bus0.out_rd_addr), 64'd0);
    check("rst_wen",   64'(bus0.out_wen),     64'd0);
    check("rst_ready", 64'(bus0.in_ready),    64'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Multiply family, early-out instance
    do_op(1'b0, OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 33, "mul");
    do_op(1'b0, OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, "mulhu");
    do_op(1'b0, OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 33, "mulh");
    do_op(1'b0, OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd4, 32'hFFFF_FFFF, 33, "mulhsu");

    // Divide boundaries with early-out
    do_op(1'b0, OP_DIV,  32'h64,        32'd0,         5'd5, 32'hFFFF_FFFF, 1,  "div0_eo");
    do_op(1'b0, OP_REMU, 32'h64,        32'd0,         5'd6, 32'h0000_0064, 1,  "remu0_eo");
    do_op(1'b0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1,  "divovf_eo");
    do_op(1'b0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, 1,  "removf_eo");
    do_op(1'b0, OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd9, 32'hFFFF_FFFF, 33, "rem_neg");
    do_op(1'b0, OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd9, 32'hFFFF_FFFD, 33, "div_neg");
    do_op(1'b0, OP_DIVU, 32'd100,       32'd7,         5'd10, 32'd14,       33, "divu");
    do_op(1'b0, OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,        33, "divu_big");

    // Same boundaries through the iterative path (early-out disabled)
    do_op(1'b1, OP_DIV,  32'h64,        32'd0,         5'd5, 32'hFFFF_FFFF, 33, "div0_it");
    do_op(1'b1, OP_REMU, 32'h64,        32'd0,         5'd6, 32'h0000_0064, 33, "remu0_it");
    do_op(1'b1, OP_DIV,  32'hFFFF_FFF9, 32'd0,         5'd7, 32'hFFFF_FFFF, 33, "divneg0_it");
    do_op(1'b1, OP_REM,  32'hFFFF_FFF9, 32'd0,         5'd8, 32'hFFFF_FFF9, 33, "remneg0_it");
    do_op(1'b1, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 33, "divovf_it");
    do_op(1'b1, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, 33, "removf_it");

    // Flush at cycle 10 of CALC, new op accepted at cycle 11
    sel = 1'b0;
    set_in(1'b0, 1'b1, OP_MUL, 32'd3, 32'd5, 5'd1);
    flag = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) set_in(1'b0, 1'b0, 3'd0, '0, '0, '0);
      if (bus0.out_valid) flag = 1'b1;
    end
    bus0.flush = 1'b1;
    @(negedge clk);
    bus0.flush = 1'b0;
    if (bus0.out_valid) flag = 1'b1;
    check("flush_novalid", 64'(flag),          64'd0);
    check("flush_ready",   64'(bus0.in_ready), 64'd1);
    check("flush_busy",    64'(bus0.busy),     64'd0);
    do_op(1'b0, OP_DIVU, 32'd100, 32'd7, 5'd12, 32'd14, 33, "after_flush");

    // Stall held in DONE with rd=0
    set_in(1'b0, 1'b1, OP_DIV, 32'h64, 32'd0, 5'd0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, '0, '0, '0);
    check("stall_v0",   64'(bus0.out_valid), 64'd1);
    check("stall_wen",  64'(bus0.out_wen),   64'd0);
    bus0.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_hold_v",  64'(bus0.out_valid), 64'd1);
      check("stall_hold_wd", 64'(bus0.out_wdata), 64'hFFFF_FFFF);
      check("stall_hold_rdy", 64'(bus0.in_ready), 64'd0);
    end
    bus0.stall = 1'b0;
    @(negedge clk);
    check("stall_rel_v",   64'(bus0.out_valid), 64'd0);
    check("stall_rel_rdy", 64'(bus0.in_ready),  64'd1);

    // Flush together with stall in DONE drops the result
    set_in(1'b0, 1'b1, OP_REMU, 32'h64, 32'd0, 5'd3);
    @(negedge clk);
    set_in(1'b0, 1'b0, 3'd0, '0, '0, '0);
    check("fs_v0", 64'(bus0.out_valid), 64'd1);
    bus0.stall = 1'b1; bus0.flush = 1'b1;
    @(negedge clk);
    check("fs_drop_v",    64'(bus0.out_valid), 64'd0);
    check("fs_drop_busy", 64'(bus0.busy),      64'd0);
    bus0.stall = 1'b0; bus0.flush = 1'b0;
    @(negedge clk);

    // Asynchronous reset at cycle 5 of CALC
    set_in(1'b0, 1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) set_in(1'b0, 1'b0, 3'd0, '0, '0, '0);
    end
    #2 rst = 1'b0;
    #1;
    check("arst_busy",  64'(bus0.busy),        64'd0);
    check("arst_valid", 64'(bus0.out_valid),   64'd0);
    check("arst_wen",   64'(bus0.out_wen),     64'd0);
    check("arst_wdata", 64'(bus0.out_wdata),   64'd0);
    check("arst_rd",    64'(bus0.out_rd_addr), 64'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("arst_ready", 64'(bus0.in_ready), 64'd1);
    flag = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus0.out_valid || bus0.busy) flag = 1'b1;
    end
    check("arst_nostale", 64'(flag), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
